fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch and sequencing front end that sits opposite the opcode decoder. It owns the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake. It presents the instruction and its 4-bit OP field to the decoder over a valid/ready handshake. It then takes the decoder's jump/branch outcome back to compute the next PC. OP 4'b1111, which the decoder leaves undefined, is treated here as HALT.

Parameters:
PC_W, 8, program counter and instruction-memory address width (4..12)
RESET_PC, 0, PC value loaded on reset
INSTR_W, 16, instruction word width; OP is always instr[INSTR_W-1:INSTR_W-4]

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level enable; fetching starts or continues only while high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  PC_W  fetch address, equal to pc
imem_ack  input  1  memory returns imem_data this cycle
imem_data  input  INSTR_W  fetched word, valid when imem_ack=1
instr  output  INSTR_W  held instruction register
op  output  4  instr[INSTR_W-1:INSTR_W-4], the opcode field sent to the decoder
instr_valid  output  1  instr/op are valid for the decoder
instr_ready  input  1  decoder consumes the instruction and jump/branch are valid
jump  input  1  decoder jump outcome, sampled on accept
branch  input  1  decoder taken-branch outcome, sampled on accept
pc  output  PC_W  address of the current instruction
halted  output  1  HALT opcode reached
retired  output  16  count of accepted instructions

Behaviour:
- Reset (async, rst_n=0) values:
  - pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, retired=0.
  - State goes to IDLE.
  - Reset mid-fetch abandons the request; any imem_ack arriving later is ignored.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE:
  - Move to FETCH when run=1.
  - imem_req=0.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack: instr<=imem_data, then go to ISSUE.
  - Minimum latency from entering FETCH to instr_valid is 1 cycle after ack.
  - imem_ack in the same cycle that FETCH is entered is legal and is accepted.
- ISSUE:
  - instr_valid=1; instr and op are held stable until accept.
  - Accept = instr_valid & instr_ready. On accept, retired increments (wraps at 2^16-1 -> 0).
  - Next PC, chosen in priority order:
    - jump=1: pc <= instr[PC_W-1:0], an absolute target.
    - else branch=1: pc <= pc + 1 + sext(instr[5:0]), a signed offset of -32..+31, modulo 2^PC_W.
    - else: pc <= pc + 1, modulo 2^PC_W.
  - After accept:
    - If op==4'b1111: go to HALT, pc is not updated, and retired still counts.
    - Else if run=1: go to FETCH.
    - Else: go to IDLE.
  - jump and branch are ignored when no accept occurs.
  - jump and branch both high: jump wins.
- HALT:
  - halted=1, instr_valid=0, imem_req=0.
  - Exits only via reset; run is ignored.
- Effect of run=0:
  - Does not abort an outstanding FETCH or ISSUE.
  - Takes effect only at the next decision point (IDLE entry).
- pc wrap-around: pc+1 from 2^PC_W-1 gives 0.
- All outputs are registered except op, which is a slice of instr, and imem_addr, which equals pc.

Test Plan:
- Reset/linear fetch: rst_n low then high, run=1, memory acks 1 cycle after req with words 0x2123, 0x3456, instr_ready=1 → imem_addr sequence 0,1,2; op 0x2 then 0x3; retired=2 after the second accept.
- Jump: word 0x7042 at pc=3, jump=1 on accept → next imem_addr=0x42; with both jump=1 and branch=1, target is still 0x42.
- Branch: word 0xD03E (offset -2) at pc=10, branch=1 → next pc=9. Same word with branch=0 → next pc=11. At pc=0xFF with no branch → next pc=0x00.
- Backpressure: hold instr_ready=0 for 5 cycles → instr_valid stays 1, instr is stable, no new imem_req, retired unchanged. Release → exactly one accept.
- HALT: word 0xF000 accepted → halted=1 next cycle, no further imem_req for 20 cycles with run=1, retired incremented once, pc unchanged.
- Async reset mid-fetch: assert rst_n low while imem_req=1 and before ack, then pulse imem_ack → all outputs at reset values immediately, pc=RESET_PC, the stray ack is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches words over req/ack and
// issues them to the decoder over valid/ready, folding jump/branch back into the PC.
module fetch_unit #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int INSTR_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         op,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic               branch,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic [15:0]        retired
);

  localparam logic [PC_W-1:0] RESET_PC_L = RESET_PC[PC_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               req_q;
  logic               halted_q;
  logic [15:0]        retired_q;

  logic [15:0] pc_ext_s;
  logic [15:0] off_ext_s;
  logic [15:0] br_sum_s;
  logic        accept_s;
  logic        halt_op_s;

  // Branch arithmetic is done at 16 bits and truncated, giving modulo-2^PC_W wrap.
  assign pc_ext_s  = {{(16-PC_W){1'b0}}, pc_q};
  assign off_ext_s = {{10{instr_q[5]}}, instr_q[5:0]};
  assign br_sum_s  = pc_ext_s + 16'd1 + off_ext_s;
  assign accept_s  = valid_q & instr_ready;
  assign halt_op_s = (instr_q[INSTR_W-1 -: 4] == 4'b1111);

  // Next-PC selection: jump beats branch beats sequential.
  always_comb begin
    pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    if (jump) begin
      pc_d = instr_q[PC_W-1:0];
    end else if (branch) begin
      pc_d = br_sum_s[PC_W-1:0];
    end else begin
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC_L;
      instr_q   <= {INSTR_W{1'b0}};
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
          end else begin
            req_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_data;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept_s) begin
            retired_q <= retired_q + 16'd1;
            valid_q   <= 1'b0;
            if (halt_op_s) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (run) begin
                state_q <= S_FETCH;
                req_q   <= 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
        end
        S_HALT: begin
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[INSTR_W-1 -: 4];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a next-PC vector table plus hand-written
// sequences for linear fetch, backpressure, HALT and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [3:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic        auto_mem;
  int          mem_lat;
  logic        req_seen;

  fetch_unit #(.PC_W(8), .RESET_PC(0), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .op(op), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump(jump), .branch(branch),
    .pc(pc), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  start;
    logic [15:0] word;
    logic        j;
    logic        b;
    logic [7:0]  exp_pc;
    logic [3:0]  exp_op;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; the memory model answers after a configurable latency.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_mem && imem_req && !imem_ack && (mem_lat == 0 || req_seen)) begin
      imem_ack  = 1'b1;
      imem_data = mem[imem_addr];
    end else begin
      imem_ack  = 1'b0;
    end
    req_seen = imem_req && !imem_ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 16'h0000;
    instr_ready = 1'b0; jump = 1'b0; branch = 1'b0; req_seen = 1'b0;
    auto_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: instr_valid timeout, got 0, expected 1", name);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem_lat = 1;

    vecs[0] = '{8'h03, 16'h7042, 1'b1, 1'b0, 8'h42, 4'h7};
    vecs[1] = '{8'h03, 16'h7042, 1'b1, 1'b1, 8'h42, 4'h7};
    vecs[2] = '{8'h0A, 16'hD03E, 1'b0, 1'b1, 8'h09, 4'hD};
    vecs[3] = '{8'h0A, 16'hD03E, 1'b0, 1'b0, 8'h0B, 4'hD};
    vecs[4] = '{8'hFF, 16'hD03E, 1'b0, 1'b0, 8'h00, 4'hD};
    vecs[5] = '{8'hFF, 16'h1001, 1'b0, 1'b1, 8'h01, 4'h1};
    vecs[6] = '{8'h20, 16'h001F, 1'b0, 1'b1, 8'h40, 4'h0};
    vecs[7] = '{8'h05, 16'h0020, 1'b0, 1'b1, 8'hE6, 4'h0};
    vecs[8] = '{8'h30, 16'h5055, 1'b0, 1'b0, 8'h31, 4'h5};

    // Reset values and linear fetch with one-cycle memory latency.
    do_reset();
    chk("rst_pc", pc, 8'h00);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 16'd0);
    mem[0] = 16'h2123; mem[1] = 16'h3456; mem[2] = 16'h0000;
    begin
      logic [7:0] addrs [3];
      logic [3:0] ops [2];
      int na = 0;
      int no = 0;
      int n = 0;
      run = 1'b1; instr_ready = 1'b1;
      while (na < 3 && n < 40) begin
        tick();
        n++;
        if (imem_ack) begin
          addrs[na] = imem_addr;
          na++;
          if (na == 3) chk("lin_retired", retired, 16'd2);
        end
        if (instr_valid && no < 2) begin
          ops[no] = op;
          no++;
        end
      end
      chk("lin_fetch_count", na, 3);
      if (na == 3) begin
        chk("lin_addr0", addrs[0], 8'h00);
        chk("lin_addr1", addrs[1], 8'h01);
        chk("lin_addr2", addrs[2], 8'h02);
        chk("lin_op0", ops[0], 4'h2);
        chk("lin_op1", ops[1], 4'h3);
      end
    end

    // Next-PC vectors, reached via a jump at address 0; same-cycle ack.
    mem_lat = 0;
    for (int v = 0; v < 9; v++) begin
      do_reset();
      mem[0] = {8'h70, vecs[v].start};
      mem[vecs[v].start] = vecs[v].word;
      run = 1'b1; instr_ready = 1'b1;
      wait_valid($sformatf("vec%0d_first", v));
      jump = 1'b1; branch = 1'b0;
      tick();
      jump = 1'b0;
      wait_valid($sformatf("vec%0d_second", v));
      chk($sformatf("vec%0d_pc", v), pc, vecs[v].start);
      chk($sformatf("vec%0d_op", v), op, vecs[v].exp_op);
      jump = vecs[v].j; branch = vecs[v].b;
      tick();
      jump = 1'b0; branch = 1'b0;
      chk($sformatf("vec%0d_next_pc", v), pc, vecs[v].exp_pc);
      chk($sformatf("vec%0d_addr", v), imem_addr, vecs[v].exp_pc);
      chk($sformatf("vec%0d_retired", v), retired, 16'd2);
    end
    mem_lat = 1;

    // Backpressure: decoder stalls for five cycles, then takes exactly one.
    do_reset();
    mem[0] = 16'h1234; mem[1] = 16'h0000;
    run = 1'b1; instr_ready = 1'b0;
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), instr_valid, 1'b1);
      chk($sformatf("bp_instr%0d", i), instr, 16'h1234);
      chk($sformatf("bp_req%0d", i), imem_req, 1'b0);
      chk($sformatf("bp_retired%0d", i), retired, 16'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("bp_accept_valid", instr_valid, 1'b0);
    chk("bp_accept_retired", retired, 16'd1);
    repeat (6) tick();
    chk("bp_single_retired", retired, 16'd1);
    chk("bp_next_valid", instr_valid, 1'b1);
    chk("bp_next_pc", pc, 8'h01);

    // HALT: second instruction is 0xF000; nothing fetched afterwards.
    do_reset();
    mem[0] = 16'h1000; mem[1] = 16'hF000;
    run = 1'b1; instr_ready = 1'b1;
    begin
      int n = 0;
      logic prev_valid = 1'b0;
      int reqs = 0;
      while (!halted && n < 40) begin
        prev_valid = instr_valid;
        tick();
        n++;
      end
      chk("halt_reached", halted, 1'b1);
      chk("halt_latency", prev_valid, 1'b1);
      chk("halt_retired", retired, 16'd2);
      chk("halt_pc", pc, 8'h01);
      chk("halt_valid", instr_valid, 1'b0);
      for (int i = 0; i < 20; i++) begin
        tick();
        if (imem_req) reqs++;
      end
      chk("halt_no_req", reqs, 0);
      chk("halt_stays", halted, 1'b1);
      chk("halt_retired_final", retired, 16'd2);
    end

    // Asynchronous reset while a fetch is outstanding; stray ack ignored.
    do_reset();
    mem[0] = 16'h1111; mem[1] = 16'h2222;
    run = 1'b1; instr_ready = 1'b1;
    begin
      int n = 0;
      while (retired != 16'd1 && n < 40) begin
        tick();
        n++;
      end
    end
    auto_mem = 1'b0;
    chk("arst_pre_req", imem_req, 1'b1);
    chk("arst_pre_pc", pc, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("arst_req", imem_req, 1'b0);
    chk("arst_pc", pc, 8'h00);
    chk("arst_retired", retired, 16'd0);
    chk("arst_instr", instr, 16'h0000);
    chk("arst_valid", instr_valid, 1'b0);
    chk("arst_halted", halted, 1'b0);
    run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_data = 16'hF000;
    imem_ack = 1'b1;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    chk("arst_stray_instr", instr, 16'h0000);
    chk("arst_stray_valid", instr_valid, 1'b0);
    chk("arst_stray_req", imem_req, 1'b0);
    run = 1'b1;
    tick();
    chk("arst_restart_req", imem_req, 1'b1);
    chk("arst_restart_addr", imem_addr, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
